// File: rtl/loopback_pkg.sv
// loopback_pkg
// Shared definitions for the loopback skew sweep: FSM state encoding,
// number of skew taps, PRBS8 constants and a lowest-set-bit helper.
// Pattern selection macro: LOOPBACK_PRBS_EN (see loopback_pattern_gen).
package loopback_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DRIVE,
        ST_RECORD,
        ST_FINISH
    } state_e;

    localparam int         TAP_COUNT      = 8;
    localparam logic [7:0] PRBS8_SEED     = 8'hFF;
    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3 of a left-shift register
    localparam logic [7:0] PRBS8_TAP_MASK = 8'hB8;

    // Lowest tap whose bit is set; 0 when the map is empty.
    function automatic logic [2:0] lowest_tap(input logic [7:0] map);
        logic [2:0] t;
        t = 3'd0;
        for (int i = TAP_COUNT - 1; i >= 0; i--) begin
            if (map[i]) t = 3'(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/loopback_pattern_gen.sv
// loopback_pattern_gen
// Test-word source for the loopback sweep. `word` is the current pattern
// word; `advance` steps to the next word, `reseed` (priority) returns to word 0.
// Macro LOOPBACK_PRBS_EN: defined  -> PRBS8 (x^8+x^6+x^5+x^4+1, seed 0xFF)
//                         undefined -> counting pattern, word k = k+1
// Ports:
//   clk, rst      clock, async active-high reset
//   reseed        load word 0
//   advance       step to the next word
//   word[7:0]     current pattern word
module loopback_pattern_gen
    import loopback_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       reseed,
    input  logic       advance,
    output logic [7:0] word
);

`ifdef LOOPBACK_PRBS_EN
    localparam logic [7:0] SEED = PRBS8_SEED;
`else
    localparam logic [7:0] SEED = 8'h01;
`endif

    logic [7:0] word_q;
    logic [7:0] word_d;

    always_comb begin
`ifdef LOOPBACK_PRBS_EN
        // Fibonacci form: shift left, XOR of tapped bits enters at bit 0
        word_d = {word_q[6:0], ^(word_q & PRBS8_TAP_MASK)};
`else
        word_d = word_q + 8'd1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          word_q <= SEED;
        else if (reseed)  word_q <= SEED;
        else if (advance) word_q <= word_d;
    end

    assign word = word_q;

endmodule

// File: rtl/loopback_skew_sweep.sv
// loopback_skew_sweep
// Steps a loopback skew line through all 8 taps. For each tap it idles,
// drives a pattern burst, compares the returned words against a delayed
// copy of what was sent and records pass/fail per tap.
// Pattern macro: LOOPBACK_PRBS_EN (PRBS8 when defined, counting otherwise).
// Ports:
//   clk, rst        clock, async active-high reset
//   start, abort    begin a sweep / terminate it (abort wins)
//   skew_sel[2:0]   tap applied to the loopback skew line
//   tx_data[7:0]    word driven into the loopback
//   rx_data[7:0]    word returned from the loopback
//   busy, done      sweep running / sweep results valid
//   pass_map[7:0]   bit t = tap t saw no mismatches
//   best_tap[2:0]   lowest passing tap (0 if none)
//   any_pass        OR of pass_map
//
// state  | meaning
// IDLE   | waiting for start, results held
// SETTLE | tx idle at 0x00 while the new tap settles
// DRIVE  | pattern burst out, returned words checked
// RECORD | fold fail flag into pass_map, pick next tap
// FINISH | results published, done raised
module loopback_skew_sweep
    import loopback_pkg::*;
#(
    parameter int PATTERN_LEN   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int RX_LATENCY    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] skew_sel,
    output logic [7:0] tx_data,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_map,
    output logic [2:0] best_tap,
    output logic       any_pass
);

    localparam int         DRIVE_LEN   = PATTERN_LEN + RX_LATENCY;
    localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_CYCLES - 1);
    localparam logic [8:0] DRIVE_LOAD  = 9'(DRIVE_LEN - 1);
    localparam logic [8:0] LAST_WORD   = 9'(PATTERN_LEN - 1);
    localparam logic [8:0] FIRST_CMP   = 9'(RX_LATENCY);
    localparam logic [2:0] LAST_TAP    = 3'(TAP_COUNT - 1);

    state_e     state_q;
    logic [8:0] cnt_q;
    logic [2:0] tap_q;
    logic [7:0] tx_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] map_q;
    logic [2:0] best_q;
    logic       any_q;
    logic       fail_q;
    logic [7:0] dl_q [RX_LATENCY];

    logic [8:0] drive_idx;
    logic       settle_last;
    logic       more_words;
    logic       gen_reseed;
    logic       gen_advance;
    logic [7:0] gen_word;
    logic       mismatch;
    logic [7:0] map_d;

    // Timer counts down; the DRIVE cycle index is recovered from it.
    assign drive_idx   = DRIVE_LOAD - cnt_q;
    assign settle_last = (state_q == ST_SETTLE) && (cnt_q == 9'd0);
    assign more_words  = drive_idx < LAST_WORD;

    // tx is registered, so the generator runs one word ahead: word 0 is
    // taken on the last SETTLE cycle, word k+1 during DRIVE cycle k.
    assign gen_advance = settle_last || ((state_q == ST_DRIVE) && more_words);
    assign gen_reseed  = (state_q != ST_DRIVE) && !settle_last;

    assign mismatch = (state_q == ST_DRIVE) && (drive_idx >= FIRST_CMP)
                      && (rx_data != dl_q[RX_LATENCY-1]);

    assign map_d = fail_q ? map_q : (map_q | (8'd1 << tap_q));

    loopback_pattern_gen u_gen (
        .clk     (clk),
        .rst     (rst),
        .reseed  (gen_reseed),
        .advance (gen_advance),
        .word    (gen_word)
    );

    // Expected-word pipeline: dl_q[RX_LATENCY-1] is tx_data from RX_LATENCY cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RX_LATENCY; i++) dl_q[i] <= 8'h00;
        end else begin
            dl_q[0] <= tx_q;
            for (int i = 1; i < RX_LATENCY; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            tap_q   <= 3'd0;
            tx_q    <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            map_q   <= 8'h00;
            best_q  <= 3'd0;
            any_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            tx_q    <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            map_q   <= 8'h00;
            best_q  <= 3'd0;
            any_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= SETTLE_LOAD;
                        tap_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        map_q   <= 8'h00;
                        best_q  <= 3'd0;
                        any_q   <= 1'b0;
                        fail_q  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 9'd0) begin
                        state_q <= ST_DRIVE;
                        cnt_q   <= DRIVE_LOAD;
                        tx_q    <= gen_word;
                    end else begin
                        cnt_q   <= cnt_q - 9'd1;
                        tx_q    <= 8'h00;
                    end
                end
                ST_DRIVE: begin
                    if (mismatch) fail_q <= 1'b1;
                    if (cnt_q == 9'd0) begin
                        state_q <= ST_RECORD;
                        tx_q    <= 8'h00;
                    end else begin
                        cnt_q   <= cnt_q - 9'd1;
                        tx_q    <= more_words ? gen_word : 8'h00;
                    end
                end
                ST_RECORD: begin
                    map_q  <= map_d;
                    fail_q <= 1'b0;
                    if (tap_q == LAST_TAP) begin
                        state_q <= ST_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        best_q  <= lowest_tap(map_d);
                        any_q   <= |map_d;
                    end else begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= SETTLE_LOAD;
                        tap_q   <= tap_q + 3'd1;
                    end
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign skew_sel = tap_q;
    assign tx_data  = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_map = map_q;
    assign best_tap = best_q;
    assign any_pass = any_q;

endmodule

// File: tb/tb_loopback_skew_sweep.sv
// tb_loopback_skew_sweep
// Directed bench for loopback_skew_sweep with a behavioural loopback
// (configurable delay, optional bit-0 corruption on selected taps).
module tb_loopback_skew_sweep;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [2:0] skew_sel;
    logic [7:0] tx_data, rx_data;
    logic       busy, done;
    logic [7:0] pass_map;
    logic [2:0] best_tap;
    logic       any_pass;

    int n_checks = 0;
    int n_pass   = 0;
    int lb_delay = 2;
    bit corrupt  = 1'b0;
    logic [7:0] hist [4];

`ifdef LOOPBACK_PRBS_EN
    localparam logic [7:0] WORD0 = 8'hFF;
    localparam logic [7:0] WORD1 = 8'hFE;
`else
    localparam logic [7:0] WORD0 = 8'h01;
    localparam logic [7:0] WORD1 = 8'h02;
`endif

    loopback_skew_sweep dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .skew_sel (skew_sel),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done),
        .pass_map (pass_map),
        .best_tap (best_tap),
        .any_pass (any_pass)
    );

    always #5 clk = ~clk;

    // hist[i] holds tx_data from i+1 cycles ago
    always @(posedge clk) begin
        hist[0] <= tx_data;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
    end

    assign rx_data = hist[lb_delay-1]
                   ^ {7'd0, (corrupt && (skew_sel inside {3'd0, 3'd1, 3'd2, 3'd7}))};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Start from IDLE and count cycles until done (bounded).
    task automatic run_sweep(output int n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_tap(input logic [2:0] t, output bit ok);
        int i;
        i = 0;
        while (skew_sel != t && i < 300) begin
            @(negedge clk);
            i++;
        end
        ok = (skew_sel == t);
    endtask

    initial begin
        int n;
        bit ok, poked;
        for (int i = 0; i < 4; i++) hist[i] = 8'h00;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_map", 16'(pass_map), 16'h0);
        chk("rst_best", 16'(best_tap), 16'h0);
        chk("rst_any", 16'(any_pass), 16'h0);
        chk("rst_skew", 16'(skew_sel), 16'h0);
        chk("rst_tx", 16'(tx_data), 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // ideal loopback
        run_sweep(n);
        chk("ideal_latency", 16'(n), 16'd185);
        chk("ideal_map", 16'(pass_map), 16'hFF);
        chk("ideal_best", 16'(best_tap), 16'h0);
        chk("ideal_any", 16'(any_pass), 16'h1);
        chk("ideal_busy", 16'(busy), 16'h0);
        @(negedge clk);
        chk("done_hold", 16'(done), 16'h1);

        // corrupted taps 0,1,2,7
        corrupt = 1'b1;
        run_sweep(n);
        corrupt = 1'b0;
        chk("corr_latency", 16'(n), 16'd185);
        chk("corr_map", 16'(pass_map), 16'h78);
        chk("corr_best", 16'(best_tap), 16'h3);
        chk("corr_any", 16'(any_pass), 16'h1);

        // loopback one cycle too slow
        lb_delay = 3;
        run_sweep(n);
        lb_delay = 2;
        chk("slow_done", 16'(done), 16'h1);
        chk("slow_map", 16'(pass_map), 16'h00);
        chk("slow_any", 16'(any_pass), 16'h0);
        chk("slow_best", 16'(best_tap), 16'h0);

        // abort during DRIVE of tap 4, then a fresh sweep
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_tap(3'd4, ok);
        chk("abort_reach_tap4", 16'(ok), 16'h1);
        repeat (6) @(negedge clk);
        chk("abort_pre_busy", 16'(busy), 16'h1);
        chk("abort_pre_map", 16'(pass_map), 16'h0F);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_done", 16'(done), 16'h0);
        chk("abort_map", 16'(pass_map), 16'h00);
        chk("abort_tx", 16'(tx_data), 16'h00);
        run_sweep(n);
        chk("after_abort_latency", 16'(n), 16'd185);
        chk("after_abort_map", 16'(pass_map), 16'hFF);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("both_busy", 16'(busy), 16'h0);
        chk("both_done", 16'(done), 16'h0);
        chk("both_map", 16'(pass_map), 16'h00);

        // start re-pulsed while busy at tap 3
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        poked = 1'b0;
        while (!done && n < 400) begin
            if (!poked && skew_sel == 3'd3) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("restart_poked", 16'(poked), 16'h1);
        chk("restart_latency", 16'(n), 16'd185);
        chk("restart_map", 16'(pass_map), 16'hFF);

        // async reset during SETTLE of tap 5
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_tap(3'd5, ok);
        chk("rst_reach_tap5", 16'(ok), 16'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 16'(busy), 16'h0);
        chk("arst_skew", 16'(skew_sel), 16'h0);
        chk("arst_map", 16'(pass_map), 16'h00);
        chk("arst_tx", 16'(tx_data), 16'h00);
        chk("arst_done", 16'(done), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("post_rst_skew", 16'(skew_sel), 16'h0);
        chk("post_rst_settle_tx", 16'(tx_data), 16'h00);
        repeat (4) @(negedge clk);
        n += 4;
        chk("post_rst_word0", 16'(tx_data), 16'(WORD0));
        @(negedge clk);
        n++;
        chk("post_rst_word1", 16'(tx_data), 16'(WORD1));
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_latency", 16'(n), 16'd185);
        chk("post_rst_map", 16'(pass_map), 16'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
